sc_canonical_engine: RTL and testbench
======================================

Name: sc_canonical_engine

Overview:
- Runtime-programmable stochastic-computing canonical-form evaluator.
- Weight matrix (NUM_OUTPUTS x 2**NUM_VARS entries, each 0..2**NUM_CONSTS) held in a writable register file, not fixed at elaboration.
- Constant bitstream generated internally by an exact binary counter. Variable bits arrive on a valid/ready stream.
- Produces registered output bits for one stream of STREAM_LEN beats per start; sits between SC bitstream generators and downstream counters/decoders.

Parameters:
- NUM_CONSTS, 4, constant-input bits; weight resolution 2**NUM_CONSTS.
- NUM_VARS, 2, variable-input bits per beat.
- NUM_OUTPUTS, 2, output bitstreams.
- STREAM_LEN, 16, beats per run; must be >= 1.
- WGT_W, NUM_CONSTS+1, weight entry width (derived).
- ACC_W, $clog2(STREAM_LEN+1), per-output count width (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- cfg_we  in  1  weight write strobe.
- cfg_addr  in  $clog2(NUM_OUTPUTS*2**NUM_VARS)  entry index, k*2**NUM_VARS+v.
- cfg_wdata  in  WGT_W  weight value.
- start  in  1  begin a run.
- in_valid  in  1  var_inputs valid.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- var_inputs  in  NUM_VARS  variable bits for this beat.
- out_valid  out  1  out_bits valid.
- out_ready  in  1  downstream accepts out_bits.
- out_bits  out  NUM_OUTPUTS  canonical-form outputs.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run end.
- counts  out  NUM_OUTPUTS*ACC_W  ones per output (SC_CF_ACC_EN only; otherwise tied 0).

Behaviour:
- Reset: all weights 0, state IDLE, const counter 0, beat counter 0. Outputs in_ready, out_valid, out_bits, busy, done, counts are all 0.
- Output function per beat: out_bits[k] = OR over v of (var_inputs==v) AND (c < W[k][v]).
  - c is the const counter value.
  - W==0 gives 0; W==2**NUM_CONSTS gives a pure one-hot var term.
- Config writes:
  - Accepted only in IDLE; cfg_we while busy is ignored.
  - cfg_wdata > 2**NUM_CONSTS is clamped to 2**NUM_CONSTS.
  - Out-of-range cfg_addr is ignored.
  - A write and a start in the same cycle: the write lands first, then the run starts.
- FSM IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: start=1 clears c, the beat counter and counts, and enters RUN.
  - RUN: in_ready = !out_valid || out_ready. On each accepted beat: out_bits registers the function (latency 1 cycle), out_valid sets, c increments mod 2**NUM_CONSTS, beat counter increments. When the accepted beat is number STREAM_LEN, go to DRAIN.
  - DRAIN: in_ready=0. When out_valid is cleared by out_ready, pulse done for one cycle and return to IDLE.
- out_valid clears on out_ready without a new beat. A simultaneous accept plus out_ready keeps out_valid=1 with new data.
- start outside IDLE is ignored.
- c wraps when STREAM_LEN > 2**NUM_CONSTS. When STREAM_LEN == 2**NUM_CONSTS with fixed var v, ones per output equal W exactly.
- Reset mid-run: immediate return to reset state. Weights are also cleared.

Optional Feature:
- Macro SC_CF_ACC_EN.
- Defined: each counts slice increments when its out_bits bit is 1 at the out_valid&&out_ready handshake. Counts clear on start and hold after done until the next start; saturating at STREAM_LEN is unreachable by construction.
- Undefined: counts tied to 0 and no accumulator flops are built.

Decomposition:
- Package sc_cf_pkg holds:
  - state enum {IDLE, RUN, DRAIN};
  - weight-clamp function;
  - address-index function k*2**NUM_VARS+v;
  - derived-width helpers.
- Sub-module sc_cf_row: combinational single-output AND-OR over one weight row, given the one-hot var vector and c. It is instantiated NUM_OUTPUTS times.

Test Plan:
- Defaults, W[0][*]={16,0,0,0}, W[1][*]={8,8,8,8}, var=0 for 16 beats with out_ready=1 -> out_bits[0]=1 every beat; out_bits[1]=1 for beats 0-7 only; counts={8,16}; done one cycle after the last output handshake.
- W[0][2]=5, var=2 for 16 beats -> ones exactly in beats 0-4; counts[0]=5.
- cfg_wdata=31 to addr 1 -> reads back 16 (all-ones for var=1); cfg_we during RUN leaves the weight unchanged.
- out_ready held 0 for 3 cycles mid-run -> in_ready=0, out_bits stable, no beat lost; final counts unchanged versus the no-stall run.
- rst asserted at beat 7 -> next cycle busy=0, out_valid=0, all weights 0; a subsequent start with var=0 gives all-zero output.
- start pulsed during RUN -> ignored; run completes after 16 beats with a single done pulse.

Source files
------------

// File: rtl/sc_cf_pkg.sv
// Shared types and elaboration-time helpers for the stochastic-computing canonical-form engine.
package sc_cf_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Width of an index over n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned acc_width(input int unsigned stream_len);
        return $clog2(stream_len + 1);
    endfunction

    function automatic int unsigned entry_index(input int unsigned k, input int unsigned v,
                                                input int unsigned num_vars);
        return k * (2 ** num_vars) + v;
    endfunction

    function automatic int unsigned clamp_weight(input int unsigned wdata,
                                                 input int unsigned num_consts);
        int unsigned w_max;
        w_max = 1 << num_consts;
        return (wdata > w_max) ? w_max : wdata;
    endfunction

endpackage

// File: rtl/sc_cf_row.sv
// One canonical-form output: OR over v of (var==v) AND (c < W[v]).
module sc_cf_row #(
    parameter int unsigned NUM_VARS = 2,
    parameter int unsigned C_W      = 4,
    parameter int unsigned WGT_W    = C_W + 1
) (
    input  logic [2**NUM_VARS-1:0]         var_onehot_i,
    input  logic [C_W-1:0]                 c_i,
    input  logic [(2**NUM_VARS)*WGT_W-1:0] wgt_row_i,
    output logic                           bit_o
);

    logic [WGT_W-1:0] c_ext;

    assign c_ext = WGT_W'(c_i);

    always_comb begin
        bit_o = 1'b0;
        for (int v = 0; v < 2 ** NUM_VARS; v++) begin
            if (var_onehot_i[v] && (c_ext < wgt_row_i[v*WGT_W +: WGT_W])) begin
                bit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sc_canonical_engine.sv
// Runtime-programmable SC canonical-form evaluator with a writable weight file.
// Define SC_CF_ACC_EN to build the per-output ones counters driving counts_o.
module sc_canonical_engine
    import sc_cf_pkg::*;
#(
    parameter int unsigned NUM_CONSTS  = 4,
    parameter int unsigned NUM_VARS    = 2,
    parameter int unsigned NUM_OUTPUTS = 2,
    parameter int unsigned STREAM_LEN  = 16,
    parameter int unsigned WGT_W       = NUM_CONSTS + 1,
    parameter int unsigned ACC_W       = acc_width(STREAM_LEN),
    parameter int unsigned ADDR_W      = idx_width(NUM_OUTPUTS * (2 ** NUM_VARS))
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [ADDR_W-1:0]            cfg_addr_i,
    input  logic [WGT_W-1:0]             cfg_wdata_i,
    input  logic                         start_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [NUM_VARS-1:0]          var_inputs_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [NUM_OUTPUTS-1:0]       out_bits_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [NUM_OUTPUTS*ACC_W-1:0] counts_o
);

    localparam int unsigned NUM_VAL = 2 ** NUM_VARS;
    localparam int unsigned NUM_ENT = NUM_OUTPUTS * NUM_VAL;

    state_e                   state_q, state_d;
    logic [WGT_W-1:0]         wgt_q [NUM_ENT];
    logic [NUM_CONSTS-1:0]    c_q, c_d;
    logic [ACC_W-1:0]         beat_q, beat_d;
    logic                     out_valid_q, out_valid_d;
    logic [NUM_OUTPUTS-1:0]   out_bits_q, out_bits_d;
    logic                     done_q, done_d;

    logic                     accept;
    logic                     last_beat;
    logic                     run_start;
    logic                     out_hs;
    logic                     cfg_wr;
    logic [WGT_W-1:0]         wgt_clamped;
    logic [NUM_VAL-1:0]       var_onehot;
    logic [NUM_OUTPUTS-1:0]   row_bits;
    logic [NUM_VAL*WGT_W-1:0] row_wgt [NUM_OUTPUTS];

    assign run_start = (state_q == StIdle) && start_i;
    assign accept    = in_valid_i && in_ready_o;
    assign last_beat = (beat_q == ACC_W'(STREAM_LEN - 1));
    assign out_hs    = out_valid_q && out_ready_i;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun:   if (accept && last_beat) state_d = StDrain;
            StDrain: if (!out_valid_q || out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready_o = (state_q == StRun) && (!out_valid_q || out_ready_i);
        busy_o     = (state_q != StIdle);
        done_d     = (state_q == StDrain) && (!out_valid_q || out_ready_i);
    end

    // Weight file: writes only land while idle, so a write alongside start precedes the run.
    assign cfg_wr      = cfg_we_i && (state_q == StIdle) && (32'(cfg_addr_i) < NUM_ENT);
    assign wgt_clamped = WGT_W'(clamp_weight(32'(cfg_wdata_i), NUM_CONSTS));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                wgt_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            wgt_q[cfg_addr_i] <= wgt_clamped;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            row_wgt[k] = '0;
            for (int v = 0; v < NUM_VAL; v++) begin
                row_wgt[k][v*WGT_W +: WGT_W] = wgt_q[entry_index(k, v, NUM_VARS)];
            end
        end
    end

    assign var_onehot = NUM_VAL'(1) << var_inputs_i;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_row
        sc_cf_row #(
            .NUM_VARS (NUM_VARS),
            .C_W      (NUM_CONSTS),
            .WGT_W    (WGT_W)
        ) u_row (
            .var_onehot_i (var_onehot),
            .c_i          (c_q),
            .wgt_row_i    (row_wgt[k]),
            .bit_o        (row_bits[k])
        );
    end

    // Datapath next state; an accept in the same cycle as out_ready overrides the clear.
    always_comb begin
        c_d         = c_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        if (run_start) begin
            c_d    = '0;
            beat_d = '0;
        end
        if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_bits_d  = row_bits;
            c_d         = c_q + 1'b1;
            beat_d      = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            c_q         <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            c_q         <= c_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            done_q      <= done_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_bits_o  = out_bits_q;
    assign done_o      = done_q;

`ifdef SC_CF_ACC_EN
    logic [ACC_W-1:0] cnt_q [NUM_OUTPUTS];
    logic [ACC_W-1:0] cnt_d [NUM_OUTPUTS];

    always_comb begin
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (run_start) begin
                cnt_d[k] = '0;
            end else if (out_hs && out_bits_q[k]) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            counts_o[k*ACC_W +: ACC_W] = cnt_q[k];
        end
    end
`else
    logic unused_out_hs;
    assign unused_out_hs = out_hs;
    assign counts_o      = '0;
`endif

endmodule

// File: tb/tb_sc_canonical_engine.sv
// Directed self-checking bench for sc_canonical_engine at default parameters.
module tb_sc_canonical_engine;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       cfg_we_i;
    logic [2:0] cfg_addr_i;
    logic [4:0] cfg_wdata_i;
    logic       start_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [1:0] var_inputs_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [1:0] out_bits_o;
    logic       busy_o;
    logic       done_o;
    logic [9:0] counts_o;

    int n_checks = 0;
    int n_errors = 0;

    // Run options read by run_stream
    int         stall_from;
    int         stall_len;
    bit         mid_start_en;
    bit         mid_cfg_en;
    bit         pre_cfg_en;
    logic [2:0] pre_cfg_addr;
    logic [4:0] pre_cfg_data;
    int         rst_at;

`ifdef SC_CF_ACC_EN
    localparam bit AccEn = 1'b1;
`else
    localparam bit AccEn = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    sc_canonical_engine u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .var_inputs_i (var_inputs_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_bits_o   (out_bits_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .counts_o     (counts_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_counts(input int c1, input int c0);
        logic [9:0] v;
        v = {c1[4:0], c0[4:0]};
        return AccEn ? 32'(v) : 32'd0;
    endfunction

    task automatic cfg_write(input logic [2:0] addr, input logic [4:0] data);
        @(negedge clk_i);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        @(negedge clk_i);
        cfg_we_i    = 1'b0;
    endtask

    task automatic clear_opts();
        stall_from   = -1;
        stall_len    = 0;
        mid_start_en = 1'b0;
        mid_cfg_en   = 1'b0;
        pre_cfg_en   = 1'b0;
        pre_cfg_addr = '0;
        pre_cfg_data = '0;
        rst_at       = 0;
    endtask

    // Streams a constant var for one run; o0/o1 hold out_bits per handshaked beat (bit n = beat n).
    task automatic run_stream(input string tag, input logic [1:0] v,
                              output logic [15:0] o0, output logic [15:0] o1);
        int   n;
        int   cyc;
        int   ndone;
        bit   stall;
        bit   prev_stall;
        logic [1:0] prev_bits;
        o0 = '0;
        o1 = '0;
        n = 0;
        ndone = 0;
        prev_stall = 1'b0;
        prev_bits = '0;
        @(negedge clk_i);
        start_i = 1'b1;
        if (pre_cfg_en) begin
            cfg_we_i    = 1'b1;
            cfg_addr_i  = pre_cfg_addr;
            cfg_wdata_i = pre_cfg_data;
        end
        @(negedge clk_i);
        start_i      = 1'b0;
        cfg_we_i     = 1'b0;
        var_inputs_i = v;
        in_valid_i   = 1'b1;
        cyc = 0;
        while (n < 16 && cyc < 200) begin
            if (rst_at != 0 && n == rst_at) begin
                rst_i = 1'b1;
                break;
            end
            stall       = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            out_ready_i = !stall;
            start_i     = mid_start_en && (cyc == 5);
            cfg_we_i    = mid_cfg_en && (cyc == 4);
            cfg_addr_i  = 3'd1;
            cfg_wdata_i = 5'd0;
            #1;
            if (done_o) ndone++;
            if (stall && out_valid_o) begin
                check_eq({tag, "_stall_in_ready"}, 32'(in_ready_o), 32'd0);
                if (prev_stall) check_eq({tag, "_stall_hold"}, 32'(out_bits_o), 32'(prev_bits));
            end
            if (out_valid_o && out_ready_i) begin
                o0[n] = out_bits_o[0];
                o1[n] = out_bits_o[1];
                n++;
            end
            prev_stall = stall && out_valid_o;
            prev_bits  = out_bits_o;
            @(negedge clk_i);
            cyc++;
        end
        start_i    = 1'b0;
        cfg_we_i   = 1'b0;
        in_valid_i = 1'b0;
        if (rst_at != 0) begin
            @(negedge clk_i);
            #1;
            check_eq({tag, "_rst_busy"}, 32'(busy_o), 32'd0);
            check_eq({tag, "_rst_out_valid"}, 32'(out_valid_o), 32'd0);
            check_eq({tag, "_rst_out_bits"}, 32'(out_bits_o), 32'd0);
            rst_i = 1'b0;
            return;
        end
        check_eq({tag, "_beats"}, 32'(n), 32'd16);
        check_eq({tag, "_no_early_done"}, 32'(ndone), 32'd0);
        #1;
        check_eq({tag, "_done_pulse"}, 32'(done_o), 32'd1);
        check_eq({tag, "_idle_after"}, 32'({busy_o, out_valid_o}), 32'd0);
        @(negedge clk_i);
        #1;
        check_eq({tag, "_done_single"}, 32'(done_o), 32'd0);
    endtask

    logic [15:0] o0, o1;

    initial begin
        rst_i        = 1'b1;
        cfg_we_i     = 1'b0;
        cfg_addr_i   = '0;
        cfg_wdata_i  = '0;
        start_i      = 1'b0;
        in_valid_i   = 1'b0;
        var_inputs_i = '0;
        out_ready_i  = 1'b0;
        clear_opts();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("reset_in_ready", 32'(in_ready_o), 32'd0);
        check_eq("reset_out_valid", 32'(out_valid_o), 32'd0);
        check_eq("reset_out_bits", 32'(out_bits_o), 32'd0);
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_done", 32'(done_o), 32'd0);
        check_eq("reset_counts", 32'(counts_o), 32'd0);

        // W[0] = {16,0,0,0}, W[1] = {8,8,8,8}
        cfg_write(3'd0, 5'd16);
        for (int a = 4; a < 8; a++) cfg_write(3'(a), 5'd8);

        run_stream("t1", 2'd0, o0, o1);
        check_eq("t1_out0", 32'(o0), 32'h0000_FFFF);
        check_eq("t1_out1", 32'(o1), 32'h0000_00FF);
        check_eq("t1_counts", 32'(counts_o), exp_counts(8, 16));

        cfg_write(3'd2, 5'd5);
        run_stream("t2", 2'd2, o0, o1);
        check_eq("t2_out0", 32'(o0), 32'h0000_001F);
        check_eq("t2_out1", 32'(o1), 32'h0000_00FF);
        check_eq("t2_counts", 32'(counts_o), exp_counts(8, 5));

        // 31 clamps to 16, written on the start cycle; the mid-run write of 0 must be ignored
        pre_cfg_en   = 1'b1;
        pre_cfg_addr = 3'd1;
        pre_cfg_data = 5'd31;
        mid_cfg_en   = 1'b1;
        run_stream("t3", 2'd1, o0, o1);
        check_eq("t3_out0", 32'(o0), 32'h0000_FFFF);
        check_eq("t3_out1", 32'(o1), 32'h0000_00FF);
        check_eq("t3_counts", 32'(counts_o), exp_counts(8, 16));
        clear_opts();

        stall_from = 6;
        stall_len  = 3;
        run_stream("t4", 2'd0, o0, o1);
        check_eq("t4_out0", 32'(o0), 32'h0000_FFFF);
        check_eq("t4_out1", 32'(o1), 32'h0000_00FF);
        check_eq("t4_counts", 32'(counts_o), exp_counts(8, 16));
        clear_opts();

        mid_start_en = 1'b1;
        run_stream("t5", 2'd2, o0, o1);
        check_eq("t5_out0", 32'(o0), 32'h0000_001F);
        check_eq("t5_counts", 32'(counts_o), exp_counts(8, 5));
        clear_opts();

        rst_at = 7;
        run_stream("t6", 2'd0, o0, o1);
        check_eq("t6_counts_cleared", 32'(counts_o), 32'd0);
        clear_opts();
        run_stream("t7", 2'd0, o0, o1);
        check_eq("t7_out0", 32'(o0), 32'd0);
        check_eq("t7_out1", 32'(o1), 32'd0);
        check_eq("t7_counts", 32'(counts_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
